// File: rtl/alu_serial32.sv
// Bit-serial ALU: add/sub/and/or processed one bit per clock, LSB first,
// with a valid/ready request side and a valid/ready result side.
module alu_serial32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ALUcontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [1:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_z;
    logic             r_n;
    logic             r_c;
    logic             r_v;

    logic             w_accept;
    logic             w_last;
    logic             w_arith;
    logic             w_b_bit;
    logic             w_sum;
    logic             w_cout;
    logic             w_bit;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_last    = (r_state == RUN) && (r_cnt == LAST_BIT);
    assign w_arith   = ~r_op[1];
    // Subtraction is a + ~b + 1: the +1 comes from the carry seeded at accept.
    assign w_b_bit   = w_arith ? (r_b[0] ^ r_op[0]) : r_b[0];
    assign w_sum     = r_a[0] ^ w_b_bit ^ r_carry;
    assign w_cout    = maj3(r_a[0], w_b_bit, r_carry);
    assign w_acc_nxt = {w_bit, r_acc[WIDTH-1:1]};

    // Select the result bit produced this cycle by the latched opcode.
    always_comb begin
        w_bit = 1'b0;
        case (r_op)
            2'b00:   w_bit = w_sum;
            2'b01:   w_bit = w_sum;
            2'b10:   w_bit = r_a[0] & r_b[0];
            2'b11:   w_bit = r_a[0] | r_b[0];
            default: w_bit = 1'b0;
        endcase
    end

    // Next-state logic for the request/compute/hold-result sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) w_state_nxt = RUN;
                else          w_state_nxt = IDLE;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
                else        w_state_nxt = RUN;
            end
            DONE: begin
                if (out_ready) w_state_nxt = IDLE;
                else           w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with registered handshake outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
        end
    end

    // Operand shifters, bit counter, carry chain, result accumulator and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_op    <= 2'b00;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= ALUcontrol;
            r_cnt   <= '0;
            r_carry <= ALUcontrol[0];
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_acc   <= w_acc_nxt;
            r_cnt   <= r_cnt + CW'(1);
            r_carry <= w_cout;
            // On the MSB cycle r_a[0]/w_b_bit are the operand sign bits.
            if (w_last) begin
                r_z <= (w_acc_nxt == '0);
                r_n <= w_bit;
                r_c <= w_arith & w_cout;
                r_v <= w_arith & (r_a[0] == w_b_bit) & (w_sum != r_a[0]);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_acc;
    assign Z         = r_z;
    assign N         = r_n;
    assign C         = r_c;
    assign V         = r_v;

endmodule

// File: tb/tb_alu_serial32.sv
// Self-checking bench for alu_serial32: directed corner cases plus random
// operations against an arithmetic reference model, with backpressure and noise.
module tb_alu_serial32;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  ALUcontrol;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        Z;
    logic        N;
    logic        C;
    logic        V;

    int checks_s;
    int failures_s;

    alu_serial32 #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUcontrol(ALUcontrol), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .Z(Z), .N(N), .C(C), .V(V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_s++;
        if (got !== exp) begin
            failures_s++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model from the arithmetic definition of each operation.
    task automatic ref_model(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] op,
                             output logic [31:0] er, output logic ez, output logic en,
                             output logic ec, output logic ev);
        logic [32:0] full;
        longint      s;
        er = 32'h0; ec = 1'b0; ev = 1'b0;
        case (op)
            2'b00: begin
                full = {1'b0, ta} + {1'b0, tb_v};
                er   = full[31:0];
                ec   = full[32];
                s    = longint'($signed(ta)) + longint'($signed(tb_v));
                ev   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b01: begin
                er = ta - tb_v;
                ec = (ta >= tb_v);
                s  = longint'($signed(ta)) - longint'($signed(tb_v));
                ev = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b10: er = ta & tb_v;
            default: er = ta | tb_v;
        endcase
        ez = (er == 32'h0);
        en = er[31];
    endtask

    task automatic noise();
        if ($urandom_range(0, 2) == 0) begin
            in_valid   = 1'b1;
            a          = $urandom;
            b          = $urandom;
            ALUcontrol = 2'($urandom);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] op,
                          input int hold);
        logic [31:0] er;
        logic        ez, en, ec, ev;
        int          lat;
        ref_model(ta, tb_v, op, er, ez, en, ec, ev);
        check_eq("ready_before_accept", in_ready, 1);
        a = ta; b = tb_v; ALUcontrol = op; in_valid = 1'b1; out_ready = 1'b0;
        step();
        lat = 0;
        while (!out_valid && lat < 100) begin
            check_eq("ready_low_run", in_ready, 0);
            noise();
            step();
            lat++;
        end
        check_eq("latency", lat, 32);
        check_eq("result", result, er);
        check_eq("flags_zncv", {Z, N, C, V}, {ez, en, ec, ev});
        for (int i = 0; i < hold; i++) begin
            noise();
            step();
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_ready", in_ready, 0);
            check_eq("hold_result", result, er);
            check_eq("hold_flags", {Z, N, C, V}, {ez, en, ec, ev});
        end
        check_eq("ready_low_at_release", in_ready, 0);
        in_valid = 1'b1; a = $urandom; b = $urandom;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("valid_drop", out_valid, 0);
        check_eq("ready_back", in_ready, 1);
        check_eq("result_kept", result, er);
    endtask

    initial begin
        logic [31:0] ra, rb;
        checks_s = 0; failures_s = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'h0; b = 32'h0; ALUcontrol = 2'b00;
        step(); step();
        reset = 1'b0;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_flags", {Z, N, C, V}, 4'h0);

        run_op(32'h7FFFFFFF, 32'h00000001, 2'b00, 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 2'b00, 1);
        run_op(32'h00000005, 32'h00000005, 2'b01, 0);
        run_op(32'h00000000, 32'h00000001, 2'b01, 2);
        run_op(32'h80000000, 32'h00000001, 2'b01, 0);
        run_op(32'hF0F0F0F0, 32'h0FF00FF0, 2'b10, 10);
        run_op(32'hF0F0F0F0, 32'h0FF00FF0, 2'b11, 0);

        // Reset in the middle of a subtraction discards it.
        a = 32'h12345678; b = 32'h00ABCDEF; ALUcontrol = 2'b01; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_result", result, 0);
        check_eq("midrst_flags", {Z, N, C, V}, 4'h0);
        check_eq("midrst_in_ready", in_ready, 1);
        run_op(32'h00000003, 32'h00000004, 2'b00, 0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = (i % 4 == 3) ? ra : $urandom;
            run_op(ra, rb, 2'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

endmodule

// File: doc/alu_serial32.md
ALU_SERIAL32 -- requirements
Module: alu_serial32

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 ALUcontrol  input  2  opcode: 00 add, 01 sub (a-b), 10 and, 11 or.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 Z, N, C, V  output  1 each  zero, negative, carry, overflow flags.

Function
REQ-013 States SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-014 Acceptance SHALL occur on a rising edge with in_valid & in_ready; a, b, ALUcontrol latched; state -> RUN; bit counter = 0; carry register = ALUcontrol[0].
REQ-015 In RUN, one bit per cycle, LSB first: bit k of b inverted when ALUcontrol[0]=1 for add/sub; sum bit = a[k] ^ b'[k] ^ carry; carry updated to majority(a[k], b'[k], carry); logic ops use a[k]&b[k] or a[k]|b[k].
REQ-016 After the edge processing bit WIDTH-1, state SHALL go to DONE; out_valid asserted exactly WIDTH edges after the accepting edge.
REQ-017 In DONE, out_valid = 1 and result/Z/N/C/V SHALL remain stable until out_valid & out_ready; on that edge state -> IDLE, out_valid -> 0.
REQ-018 No same-cycle turnaround: in_ready SHALL be 0 in the cycle out_valid & out_ready is sampled; next request accepted no earlier than the following edge.
REQ-019 in_valid while in RUN or DONE SHALL be ignored; latched operands/opcode unaffected by input changes after acceptance.
REQ-020 Z = 1 iff result == 0 (all ops).
REQ-021 N = result[WIDTH-1] (all ops).
REQ-022 C = final carry out for add/sub (sub: 1 means no borrow); C = 0 for and/or.
REQ-023 V = signed overflow for add/sub (a[MSB] == b'[MSB] and result[MSB] != a[MSB]); V = 0 for and/or.
REQ-024 result, Z, N, C, V SHALL be 0 whenever out_valid = 0 is not required; they hold last computed values until next acceptance, then are don't-care until out_valid.

Reset
REQ-025 reset SHALL force state IDLE, in_ready = 1 after the edge, out_valid = 0, result = 0, Z = N = C = V = 0, counter = 0, carry = 0.
REQ-026 reset SHALL take priority over acceptance, bit processing and output handshake in the same cycle; an in-progress operation is discarded with no out_valid.

Verification
REQ-027 WIDTH=32, add 0x7FFFFFFF + 0x00000001 -> out_valid 32 edges after accept, result 0x80000000, N=1 Z=0 C=0 V=1.
REQ-028 add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, Z=1 N=0 C=1 V=0; sub 5 - 5 -> result 0, Z=1 C=1 V=0 N=0.
REQ-029 sub 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, N=1 C=0 V=0 Z=0; sub 0x80000000 - 1 -> 0x7FFFFFFF, V=1 C=1.
REQ-030 and 0xF0F0F0F0, 0x0FF00FF0 -> 0x00F000F0, C=V=0 N=0 Z=0; or same operands -> 0xFFF0FFF0, N=1 C=V=0.
REQ-031 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid and all outputs stable; in_valid pulses during RUN/DONE with other operands -> no effect on result, in_ready stays 0.
REQ-032 reset asserted at bit 16 of a sub -> next cycle out_valid=0, result=0, flags 0, in_ready=1; subsequent add 3 + 4 -> result 7 after 32 edges.
